// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: opcode and FSM state types shared by the register ALU and its multiplier
package reg_alu_pkg;
   typedef enum logic [1:0] {OP_WRITE, OP_ADD, OP_SUB, OP_MUL} op_e;
   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_e;
endpackage

// File: rtl/reg_alu_mult.sv
// reg_alu_mult: full-width unsigned multiplier whose done flag rises LAT edges after start
module reg_alu_mult #(
   parameter int DATA_W = 16,
   parameter int LAT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  done,
   output logic [2*DATA_W-1:0]   p
);
   localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
   logic [CW-1:0] cnt;
   logic busy;
   assign done = busy && cnt == '0;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= 1'b0;
         cnt <= '0;
         p <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt <= CW'(LAT - 1);
         p <= {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      end else if (done) begin
         busy <= 1'b0;
      end else if (busy) begin
         cnt <= cnt - 1'b1;
      end
   end
endmodule

// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: register-file ALU with multi-cycle multiply and a valid/ready result handshake
module reg_alu_pipe
   import reg_alu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NUM_REGS = 4,
   parameter int MUL_LAT = 3,
   localparam int SEL_W = NUM_REGS > 2 ? $clog2(NUM_REGS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     data_i,
   input  logic [SEL_W-1:0]      reg_sel,
   input  logic [1:0]            instru,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [2*DATA_W-1:0]   data_o,
   output logic                  valid_o,
   input  logic                  ready_i
);
   localparam int DEPTH = 1 << SEL_W;
   state_e state, nxt;
   op_e op;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DATA_W-1:0] a_q, b_q, b, diff;
   logic [2*DATA_W-1:0] p;
   logic sub_q, pend, nxt_pend, nxt_ready, accept, in_range, start, done;
   assign op = op_e'(instru);
   assign accept = valid_i & ready_o;
   assign in_range = int'(reg_sel) < NUM_REGS;
   assign b = in_range ? regs[reg_sel] : '0;
   assign start = accept && op == OP_MUL;
   assign nxt_pend = accept && (op == OP_ADD || op == OP_SUB);
   assign diff = a_q - b_q;
   reg_alu_mult #(.DATA_W(DATA_W), .LAT(MUL_LAT)) u_mult (
      .clk(clk), .rst(rst), .start(start), .a(regs[0]), .b(b), .done(done), .p(p)
   );
   always_comb begin
      nxt = state;
      if (state == IDLE) nxt = pend ? HOLD : start ? MUL : IDLE;
      if (state == MUL && done) nxt = HOLD;
      if (state == HOLD && ready_i) nxt = IDLE;
      nxt_ready = nxt == IDLE && !nxt_pend;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ready_o <= 1'b0;
      end else begin
         state <= nxt;
         ready_o <= nxt_ready;
      end
   end
   // ADD/SUB stay in IDLE for one pending cycle with ready_o low, then deliver into HOLD
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         a_q <= '0;
         b_q <= '0;
         sub_q <= 1'b0;
         pend <= 1'b0;
         data_o <= '0;
         valid_o <= 1'b0;
      end else begin
         if (accept && op == OP_WRITE && in_range) regs[reg_sel] <= data_i;
         if (accept) begin
            a_q <= regs[0];
            b_q <= b;
            sub_q <= op == OP_SUB;
         end
         pend <= nxt_pend;
         if (pend) begin
            data_o <= sub_q ? {{DATA_W{diff[DATA_W-1]}}, diff}
                            : {{DATA_W{1'b0}}, a_q} + {{DATA_W{1'b0}}, b_q};
            valid_o <= 1'b1;
         end else if (state == MUL && done) begin
            data_o <= p;
            valid_o <= 1'b1;
         end else if (state == HOLD && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end
endmodule
